// File: rtl/hsi_vector_mse.sv
// Streaming MSE between one measured HSI pixel vector and one reference vector,
// both arriving as packed multi-band words; one tagged result per reference vector.
//
// state | meaning
// IDLE  | word counter at 0, no vector partially received
// RECV  | some words of the current vector accepted, waiting for the last one
module hsi_vector_mse #(
    parameter int WORD_WIDTH            = 32,
    parameter int DATA_WIDTH            = 16,
    parameter int HSI_BANDS             = 128,
    parameter int HSI_LIBRARY_SIZE      = 256,
    parameter int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    input  logic [WORD_WIDTH-1:0]            sample_word,
    input  logic [WORD_WIDTH-1:0]            ref_word,
    output logic                             mse_valid,
    output logic [2*DATA_WIDTH-1:0]          mse_out,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_id,
    output logic                             busy
);
    localparam int BPW = WORD_WIDTH / DATA_WIDTH;
    localparam int WPV = HSI_BANDS / BPW;
    localparam int SH  = $clog2(HSI_BANDS);
    localparam int WCW = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int PW  = 2 * DATA_WIDTH + $clog2(BPW);
    localparam int AW  = 2 * DATA_WIDTH + SH;
    localparam int IDW = HSI_LIBRARY_SIZE_ADDR;

    typedef enum logic {ST_IDLE, ST_RECV} state_t;

    state_t                           state_q, state_d;
    logic [WCW-1:0]                   wcnt_q, wcnt_d;
    logic [IDW-1:0]                   id_q, id_d;

    logic                             s1_v_q, s1_f_q, s1_l_q;
    logic [BPW-1:0][DATA_WIDTH-1:0]   s1_diff_q, s1_diff_d;
    logic                             s2_v_q, s2_f_q, s2_l_q;
    logic [PW-1:0]                    s2_sum_q, s2_sum_d;
    logic                             s3_v_q, s3_l_q;
    logic [AW-1:0]                    acc_q, acc_d;

    logic                             mse_valid_q, mse_valid_d;
    logic [2*DATA_WIDTH-1:0]          mse_q, mse_d;
    logic [IDW-1:0]                   mse_id_q, mse_id_d;

    logic                             accept;
    logic                             word_first;
    logic                             word_last;

    // clear wins over in_valid: the word offered in a clear cycle is dropped
    assign accept     = in_valid & ~clear;
    assign word_first = (wcnt_q == '0);
    assign word_last  = (wcnt_q == WCW'(WPV - 1));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (clear) begin
            state_d = ST_IDLE;
            wcnt_d  = '0;
        end else if (in_valid) begin
            wcnt_d = word_last ? '0 : wcnt_q + 1'b1;
            case (state_q)
                ST_IDLE: state_d = word_last ? ST_IDLE : ST_RECV;
                ST_RECV: state_d = word_last ? ST_IDLE : ST_RECV;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        logic [DATA_WIDTH-1:0]   s, r;
        logic [2*DATA_WIDTH-1:0] sq;
        s         = '0;
        r         = '0;
        sq        = '0;
        s1_diff_d = '0;
        s2_sum_d  = '0;
        for (int i = 0; i < BPW; i++) begin
            s = sample_word[i*DATA_WIDTH +: DATA_WIDTH];
            r = ref_word[i*DATA_WIDTH +: DATA_WIDTH];
            s1_diff_d[i] = (s >= r) ? (s - r) : (r - s);
        end
        for (int i = 0; i < BPW; i++) begin
            sq       = (2*DATA_WIDTH)'(s1_diff_q[i]) * (2*DATA_WIDTH)'(s1_diff_q[i]);
            s2_sum_d = s2_sum_d + PW'(sq);
        end
    end

    // first flag restarts the accumulator, so back-to-back vectors need no bubble
    always_comb begin
        acc_d       = acc_q;
        id_d        = id_q;
        mse_valid_d = 1'b0;
        mse_d       = mse_q;
        mse_id_d    = mse_id_q;
        if (s2_v_q) begin
            acc_d = s2_f_q ? AW'(s2_sum_q) : acc_q + AW'(s2_sum_q);
        end
        if (s3_v_q && s3_l_q) begin
            mse_valid_d = 1'b1;
            mse_d       = acc_q[SH +: 2*DATA_WIDTH];
            mse_id_d    = id_q;
            id_d        = (id_q == IDW'(HSI_LIBRARY_SIZE - 1)) ? '0 : id_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            id_q        <= '0;
            s1_v_q      <= 1'b0;
            s1_f_q      <= 1'b0;
            s1_l_q      <= 1'b0;
            s1_diff_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_f_q      <= 1'b0;
            s2_l_q      <= 1'b0;
            s2_sum_q    <= '0;
            s3_v_q      <= 1'b0;
            s3_l_q      <= 1'b0;
            acc_q       <= '0;
            mse_valid_q <= 1'b0;
            mse_q       <= '0;
            mse_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            s1_f_q    <= word_first;
            s1_l_q    <= word_last;
            s1_diff_q <= s1_diff_d;
            s2_f_q    <= s1_f_q;
            s2_l_q    <= s1_l_q;
            s2_sum_q  <= s2_sum_d;
            s3_l_q    <= s2_l_q;
            acc_q     <= acc_d;
            mse_q     <= mse_d;
            mse_id_q  <= mse_id_d;
            if (clear) begin
                id_q        <= '0;
                s1_v_q      <= 1'b0;
                s2_v_q      <= 1'b0;
                s3_v_q      <= 1'b0;
                mse_valid_q <= 1'b0;
            end else begin
                id_q        <= id_d;
                s1_v_q      <= accept;
                s2_v_q      <= s1_v_q;
                s3_v_q      <= s2_v_q;
                mse_valid_q <= mse_valid_d;
            end
        end
    end

    assign mse_valid = mse_valid_q;
    assign mse_out   = mse_q;
    assign mse_id    = mse_id_q;
    assign busy      = (state_q == ST_RECV) | s1_v_q | s2_v_q | s3_v_q;

endmodule

// File: tb/tb_hsi_vector_mse.sv
// Scoreboard bench for hsi_vector_mse: expected MSE/id pushed at stimulus time,
// popped and compared on every mse_valid pulse.
module tb_hsi_vector_mse;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] sample_word = '0;
    logic [31:0] ref_word = '0;
    logic        mse_valid;
    logic [31:0] mse_out;
    logic [7:0]  mse_id;
    logic        busy;

    typedef struct {longint mse; int id;} exp_t;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_id = 0;

    hsi_vector_mse dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .sample_word(sample_word), .ref_word(ref_word),
        .mse_valid(mse_valid), .mse_out(mse_out), .mse_id(mse_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mse_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mse_out", longint'(mse_out), e.mse);
                chk("mse_id", longint'(mse_id), longint'(e.id));
            end
        end
    end

    function automatic longint absd(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? longint'(a - b) : longint'(b - a);
    endfunction

    // sends nwords identical words; a full 64-word vector optionally gets a scoreboard entry
    task automatic send_vec(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] r0, input logic [15:0] r1,
                            input int nwords, input bit gaps, input bit push);
        longint d0, d1;
        exp_t   e;
        d0 = absd(s0, r0);
        d1 = absd(s1, r1);
        if (push) begin
            e.mse  = (((d0 * d0) + (d1 * d1)) * 64) >> 7;
            e.id   = exp_id;
            exp_id = (exp_id + 1) % 256;
            sb.push_back(e);
        end
        for (int w = 0; w < nwords; w++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            @(negedge clk);
            in_valid    = 1'b1;
            sample_word = {s1, s0};
            ref_word    = {r1, r0};
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear(input bit with_valid);
        @(negedge clk);
        clear       = 1'b1;
        in_valid    = with_valid;
        sample_word = 32'h0005_0009;
        ref_word    = 32'h0000_0000;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        exp_id   = 0;
    endtask

    task automatic wait_pulse(output int lat);
        lat = 1;
        while (!mse_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        #12;
        chk("rst_mse_valid", longint'(mse_valid), 0);
        chk("rst_mse_out", longint'(mse_out), 0);
        chk("rst_mse_id", longint'(mse_id), 0);
        chk("rst_busy", longint'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // identical vectors, plus exact result latency
        send_vec(16'h1234, 16'h1234, 16'h1234, 16'h1234, 64, 0, 1);
        wait_pulse(lat);
        chk("latency", lat, 4);
        repeat (3) @(negedge clk);

        // diff 2 per band, busy across the vector
        chk("busy_idle", longint'(busy), 0);
        send_vec(16'h0003, 16'h0003, 16'h0001, 16'h0001, 64, 0, 1);
        chk("busy_after_last", longint'(busy), 1);
        wait_pulse(lat);
        chk("latency2", lat, 4);
        @(negedge clk);
        chk("busy_done", longint'(busy), 0);
        chk("hold_mse", longint'(mse_out), 4);

        // full-scale diff, lane asymmetry and swapped operands
        send_vec(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 64, 0, 1);
        send_vec(16'd10, 16'd0, 16'd0, 16'd0, 64, 0, 1);
        send_vec(16'd0, 16'd0, 16'd10, 16'd0, 64, 0, 1);
        repeat (8) @(negedge clk);

        // back-to-back with random gaps, ids restart after clear
        do_clear(0);
        send_vec(16'd7, 16'd2, 16'd5, 16'd4, 64, 1, 1);
        send_vec(16'd1, 16'd9, 16'd0, 16'd10, 64, 1, 1);
        send_vec(16'd300, 16'd1, 16'd0, 16'd1, 64, 0, 1);
        repeat (8) @(negedge clk);

        // clear drops an in-flight completed vector
        send_vec(16'd50, 16'd50, 16'd0, 16'd0, 64, 0, 0);
        do_clear(0);
        repeat (6) @(negedge clk);

        // clear mid-vector with in_valid high
        send_vec(16'd9, 16'd9, 16'd0, 16'd0, 10, 0, 0);
        chk("busy_partial", longint'(busy), 1);
        do_clear(1);
        chk("busy_cleared", longint'(busy), 0);
        send_vec(16'd3, 16'd3, 16'd1, 16'd1, 64, 0, 1);
        repeat (8) @(negedge clk);

        // async reset mid-vector
        send_vec(16'd9, 16'd9, 16'd0, 16'd0, 10, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_mse_valid", longint'(mse_valid), 0);
        chk("rst2_mse_out", longint'(mse_out), 0);
        chk("rst2_mse_id", longint'(mse_id), 0);
        chk("rst2_busy", longint'(busy), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_id = 0;
        send_vec(16'd3, 16'd3, 16'd1, 16'd1, 64, 0, 1);
        repeat (8) @(negedge clk);

        chk("sb_empty", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
